dice_display: RTL

Two-digit seven-segment output stage for the dice roller. Consumes the 5-bit die roll and its one-cycle valid strobe from the post-processing stage. Plays a short spinning animation, then shows the roll in decimal on a time-multiplexed two-digit common-anode display. Sits at the top level between post-processing and the board display pins.

---
 rtl/dice_pkg.sv | 24 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/dice_display.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared types and glyph constants for the dice roller seven-segment display.
package dice_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    SPIN  = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-glyph decoder; codes 10..15 produce a blank digit.
module seg7_decode
  import dice_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] glyph_c
);

  always_comb begin
    glyph_c = SEG_BLANK;
    case (digit)
      4'd0:    glyph_c = SEG_0;
      4'd1:    glyph_c = SEG_1;
      4'd2:    glyph_c = SEG_2;
      4'd3:    glyph_c = SEG_3;
      4'd4:    glyph_c = SEG_4;
      4'd5:    glyph_c = SEG_5;
      4'd6:    glyph_c = SEG_6;
      4'd7:    glyph_c = SEG_7;
      4'd8:    glyph_c = SEG_8;
      4'd9:    glyph_c = SEG_9;
      default: glyph_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/dice_display.sv
// Two-digit multiplexed seven-segment stage: spin animation, then the roll in decimal.
module dice_display
  import dice_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned SPIN_STEP   = 2500000,
  parameter int unsigned SPIN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] i_roll,
  input  logic       i_valid,
  output logic [6:0] o_seg,
  output logic [1:0] o_an,
  output logic       o_busy
);

  localparam int unsigned REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned STEP_W  = (SPIN_STEP > 1) ? $clog2(SPIN_STEP) : 1;
  localparam int unsigned FRAME_W = $clog2(SPIN_FRAMES + 1);

  localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SPIN_STEP - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SPIN_FRAMES - 1);

  state_t               state, state_n;
  logic [4:0]           value, value_n;
  logic [STEP_W-1:0]    step_cnt, step_n;
  logic [FRAME_W-1:0]   frame_cnt, frame_n;
  logic [REF_W-1:0]     refresh_cnt, refresh_n;
  logic                 sel, sel_n;

  logic [1:0] tens;
  logic [4:0] tens_x10;
  logic [3:0] ones;
  logic [3:0] digit;
  logic [6:0] glyph_c;
  logic [2:0] spin_idx;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       busy_n;

  // Next-state and counter logic; a strobe restarts the spin from any state
  always_comb begin
    state_n   = state;
    value_n   = value;
    step_n    = step_cnt;
    frame_n   = frame_cnt;
    refresh_n = (refresh_cnt == REF_LAST) ? '0 : refresh_cnt + 1'b1;
    sel_n     = (refresh_cnt == REF_LAST) ? ~sel : sel;

    if (i_valid) begin
      value_n = i_roll;
      step_n  = '0;
      frame_n = '0;
      state_n = SPIN;
    end else if (state == SPIN) begin
      if (step_cnt == STEP_LAST) begin
        step_n  = '0;
        frame_n = frame_cnt + 1'b1;
        if (frame_cnt == FRAME_LAST) state_n = SHOW;
      end else begin
        step_n = step_cnt + 1'b1;
      end
    end
  end

  // Binary to BCD by comparison and subtraction
  always_comb begin
    tens     = 2'd0;
    tens_x10 = 5'd0;
    if (value_n >= 5'd30) begin
      tens     = 2'd3;
      tens_x10 = 5'd30;
    end else if (value_n >= 5'd20) begin
      tens     = 2'd2;
      tens_x10 = 5'd20;
    end else if (value_n >= 5'd10) begin
      tens     = 2'd1;
      tens_x10 = 5'd10;
    end
    ones = 4'(value_n - tens_x10);
  end

  // Digit mux ahead of the single decoder; code 15 blanks a zero tens digit
  assign digit = sel_n ? ((tens == 2'd0) ? 4'd15 : {2'b00, tens}) : ones;

  seg7_decode u_decode (
    .digit   (digit),
    .glyph_c (glyph_c)
  );

  // Outputs are derived from next-state values so they register in step with the state
  always_comb begin
    spin_idx = 3'(32'(frame_n) % 32'd6);
    busy_n   = (state_n == SPIN);
    an_n     = ~(2'b01 << sel_n);
    case (state_n)
      SPIN:    seg_n = ~(7'b0000001 << spin_idx);
      SHOW:    seg_n = glyph_c;
      default: seg_n = SEG_DASH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BLANK;
      value       <= '0;
      step_cnt    <= '0;
      frame_cnt   <= '0;
      refresh_cnt <= '0;
      sel         <= 1'b0;
      o_seg       <= SEG_DASH;
      o_an        <= 2'b10;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_n;
      value       <= value_n;
      step_cnt    <= step_n;
      frame_cnt   <= frame_n;
      refresh_cnt <= refresh_n;
      sel         <= sel_n;
      o_seg       <= seg_n;
      o_an        <= an_n;
      o_busy      <= busy_n;
    end
  end

endmodule
